// File: rtl/acc_pkg.sv
// Shared widths and operand types for the MAC accumulator stage.
package acc_pkg;

  localparam int unsigned DIN_W = 20;
  localparam int unsigned ACC_W = 22;
  localparam int unsigned TERMS = 4;
  localparam int unsigned CNT_W = 13;

  typedef logic signed [DIN_W-1:0] din_t;
  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/acc_seq.sv
// Free-running window sequencer: phase counter 0..TERMS-1 with first/last-term decodes.
module acc_seq #(
  parameter int unsigned TERMS = 4,
  parameter int unsigned CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  output logic             sel,
  output logic             en,
  output logic [CNT_W-1:0] phase
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS - 1);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] phase_d;

  always_comb begin
    phase_d = phase_q + CNT_W'(1);
    if (phase_q == LAST) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Decodes are gated by rst directly so they drop in the same cycle reset rises.
  always_comb begin
    sel = !rst && (phase_q == '0);
    en  = !rst && (phase_q == LAST);
  end

  assign phase = phase_q;

endmodule

// File: rtl/acc_adder_ctrl.sv
// Accumulator-stage core: zero-latency sign-extending adder plus the window sequencer.
module acc_adder_ctrl #(
  parameter int unsigned DIN_W = acc_pkg::DIN_W,
  parameter int unsigned ACC_W = acc_pkg::ACC_W,
  parameter int unsigned TERMS = acc_pkg::TERMS,
  parameter int unsigned CNT_W = acc_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DIN_W-1:0] din,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [ACC_W-1:0] sum,
  output logic                    sel,
  output logic                    en,
  output logic [CNT_W-1:0]        phase
);

  logic signed [ACC_W-1:0] din_ext;

  // Signed size cast sign-extends and stays legal when ACC_W == DIN_W.
  always_comb begin
    din_ext = ACC_W'(din);
    sum     = din_ext + acc_in;
  end

  acc_seq #(
    .TERMS (TERMS),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .en    (en),
    .phase (phase)
  );

endmodule

// File: tb/tb_acc_adder_ctrl.sv
// Scoreboard bench for acc_adder_ctrl: stimulus pushes model expectations, monitor compares.
module tb_acc_adder_ctrl;

  localparam int TERMS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] din = '0;
  logic [21:0] acc_in = '0;
  logic [21:0] sum;
  logic        sel;
  logic        en;
  logic [12:0] phase;

  acc_adder_ctrl #(
    .DIN_W (20),
    .ACC_W (22),
    .TERMS (TERMS),
    .CNT_W (13)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .acc_in (acc_in),
    .sum    (sum),
    .sel    (sel),
    .en     (en),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] sum;
    logic        sel;
    logic        en;
    logic [12:0] phase;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycles elapsed since the last reset edge.
  int   cyc = 0;
  bit   known = 0;
  logic [21:0] last_sum = '0;

  function automatic logic [21:0] ref_sum(logic [19:0] d, logic [21:0] a);
    longint sd = longint'(d);
    longint sa = longint'(a);
    if (d[19]) sd = sd - (longint'(1) << 20);
    if (a[21]) sa = sa - (longint'(1) << 22);
    return 22'((sd + sa) & 64'h3FFFFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      cyc   = 0;
      known = 1;
    end else begin
      cyc = cyc + 1;
    end
  endtask

  task automatic apply(input bit r, input logic [19:0] d, input logic [21:0] a);
    exp_t e;
    int   ph;
    #1;
    rst    = r;
    din    = d;
    acc_in = a;
    ph      = cyc % TERMS;
    e.sum   = ref_sum(d, a);
    e.sel   = !r && (ph == 0);
    e.en    = !r && (ph == TERMS - 1);
    e.phase = 13'(ph);
    last_sum = e.sum;
    if (known) q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [19:0] d, input logic [21:0] a);
    tick();
    apply(r, d, a);
  endtask

  task automatic cmp(input string name, input logic [21:0] act, input logic [21:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("sum",   sum,          e.sum);
        cmp("sel",   22'(sel),     22'(e.sel));
        cmp("en",    22'(en),      22'(e.en));
        cmp("phase", 22'(phase),   22'(e.phase));
      end
    end
  end

  initial begin : stim
    logic [21:0] bias;
    logic [21:0] fb;
    logic [19:0] wd[4];
    int          guard;

    // Reset held for a few cycles, then 12 free-running cycles.
    repeat (3) step(1, 20'h00005, 22'h000003);
    for (int i = 0; i < 12; i++) step(0, 20'h00005, 22'h000003);

    // Directed adder vectors.
    step(0, 20'hFFFFF, 22'h000000);
    step(0, 20'h80000, 22'h000001);
    step(0, 20'h7FFFF, 22'h1FFFFF);
    step(0, 20'h00000, 22'h3FFFFF);

    // Randomized operands with occasional reset pulses.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 11) == 0), 20'($urandom), 22'($urandom));
    step(0, '0, '0);

    // Reset at phase 2 aborts the window.
    guard = 0;
    while ((cyc % TERMS) != 1 && guard < 16) begin
      step(0, 20'($urandom), 22'($urandom));
      guard++;
    end
    tick();
    apply(1, 20'h00010, 22'h000020);
    for (int i = 0; i < 5; i++) step(0, 20'($urandom), 22'($urandom));

    // Full window with bench-side feedback register.
    guard = 0;
    while ((cyc % TERMS) != TERMS - 1 && guard < 16) begin
      step(0, 20'($urandom), 22'($urandom));
      guard++;
    end
    bias = 22'h3FFFFE;
    fb   = '0;
    wd[0] = 20'd10; wd[1] = 20'd20; wd[2] = 20'd30; wd[3] = 20'd40;
    for (int k = 0; k < TERMS; k++) begin
      tick();
      fb = last_sum;
      apply(0, wd[k], ((cyc % TERMS) == 0) ? bias : fb);
    end
    @(negedge clk);
    cmp("window_sum", sum, 22'h000062);
    cmp("window_en", 22'(en), 22'h1);

    step(0, '0, '0);
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    cmp("queue_drained", 22'(q.size()), 22'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
